ir_err_calc: RTL
================

Name: ir_err_calc

Overview:
Produces the `error`/`err_vld`/`line_present` inputs that the PID steering controller consumes.
- Drives the IR emitter enable and waits a settle time.
- Sequences 8 IR receiver channels (4 left/right pairs) through the A2D conversion handshake.
- Accumulates a position-weighted signed difference, saturates it to 16 bits, and publishes it once per frame with a one-cycle `err_vld`.

Parameters:
FAST_SIM, 0, 1 shortens emitter settle time from 4096 to 32 clk cycles for simulation.
LINE_THRES, 12'h040, minimum A2D reading that counts as line detected.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  enables continuous frame acquisition
IR_en  output  1  IR emitter enable, high from SETTLE through last conversion
strt_cnv  output  1  one-cycle pulse requesting an A2D conversion
chnnl  output  3  A2D channel select, stable from strt_cnv until cnv_cmplt
cnv_cmplt  input  1  A2D conversion done, res valid this cycle
res  input  12  unsigned A2D result
error  output  16  signed saturated line-position error
err_vld  output  1  one-cycle pulse: error/line_present updated
line_present  output  1  any reading in last frame >= LINE_THRES

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator 0, pair index 0.
- States: IDLE, SETTLE, CONV_R, WAIT_R, CONV_L, WAIT_L, DONE.
- IDLE:
  - IR_en=0.
  - If en=1, go to SETTLE next cycle and clear the settle counter, accumulator, pair index p and the frame line flag.
- SETTLE:
  - IR_en=1; counter counts up.
  - After 4096 cycles (32 if FAST_SIM) go to CONV_R.
- CONV_R:
  - chnnl=2p (right sensor of pair p); strt_cnv=1 for exactly this cycle; go to WAIT_R.
- WAIT_R:
  - Hold chnnl.
  - On cnv_cmplt=1, sample res: acc += res<<p, and set the line flag if res>=LINE_THRES.
  - Go to CONV_L.
- CONV_L / WAIT_L:
  - Same as CONV_R/WAIT_R with chnnl=2p+1 (left sensor) and acc -= res<<p.
  - Then: if p<3, p++ and go to CONV_R; else go to DONE.
- DONE:
  - Register error = sat16(acc); line_present = line flag; err_vld=1 for this one cycle.
  - IR_en drops this cycle.
  - Next state: SETTLE if en=1, else IDLE.
- Weights: pair 0 (chnnl 0/1) innermost ×1, pair 1 ×2, pair 2 ×4, pair 3 outermost ×8. Positive error = line right of center.
- Arithmetic:
  - Accumulator is 18-bit signed, range ±61425.
  - sat16 clamps to 16'h7FFF / 16'h8000, otherwise passes acc[15:0].
- cnv_cmplt outside WAIT_R/WAIT_L is ignored, including in the same cycle as strt_cnv.
- Timing rules:
  - strt_cnv never asserts while a conversion is outstanding.
  - Minimum 2 cycles between consecutive strt_cnv pulses.
- en deasserted mid-frame (SETTLE/CONV/WAIT):
  - Return to IDLE next cycle; IR_en=0.
  - No err_vld; error and line_present hold their previous values.
  - A late cnv_cmplt is ignored.
- rst mid-frame: immediate return to reset values, including error.
- error/line_present change only in the DONE cycle and hold between frames.
- A frame takes settle + 8 conversion latencies + 9 cycles of overhead.

Decomposition:
- Shared package ir_pkg:
  - state enum `ir_state_t`
  - `SETTLE_CYC`=4096, `SETTLE_CYC_FAST`=32
  - `NUM_PAIRS`=4
  - `ERR_MAX`=16'h7FFF, `ERR_MIN`=16'h8000
- Sub-module ir_settle_tmr: 12-bit counter with clr/en inputs and a `done` output, parameterized by FAST_SIM.
- Accumulate/saturate stays inline.

Test Plan:
- All 8 channels return 12'h100, A2D responding 5 cycles after strt_cnv → chnnl sequence 0,1,2,…,7; error=16'h0000; line_present=1; one err_vld per frame.
- chnnl 7 (pair 3 left) = 12'hFFF, all others 0 → error = -32760 = 16'h8008; line_present=1.
- Channels 1,3,5,7 = 12'hFFF, channels 0,2,4,6 = 0 → acc=-61425 → error=16'h8000. Mirror case (right channels 12'hFFF) → error=16'h7FFF.
- All channels 12'h020 → line_present=0, error=0. Then one frame with chnnl 2 = 12'h040 → line_present=1, error=+2×64=16'h0080.
- Drop en during WAIT_L of pair 1, with cnv_cmplt arriving 2 cycles later → no err_vld, error unchanged, IR_en low next cycle, FSM in IDLE. Re-raise en → full frame starting at chnnl 0.
- Assert rst during WAIT_R after a completed frame with error=16'h0080 → error, line_present, IR_en, strt_cnv all 0 immediately; no strt_cnv until a new SETTLE completes.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR line-sensor error calculator.
// Includes the 16-bit saturation used when publishing the accumulated error.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONV_R,
    WAIT_R,
    CONV_L,
    WAIT_L,
    DONE
  } ir_state_t;

  localparam int SETTLE_CYC      = 4096;
  localparam int SETTLE_CYC_FAST = 32;
  localparam int NUM_PAIRS       = 4;

  localparam logic [15:0] ERR_MAX = 16'h7FFF;
  localparam logic [15:0] ERR_MIN = 16'h8000;

  function automatic logic [15:0] sat16(input logic signed [17:0] a);
    if (a > 18'sd32767)
      return ERR_MAX;
    else if (a < -18'sd32768)
      return ERR_MIN;
    else
      return a[15:0];
  endfunction

endpackage

// File: rtl/ir_settle_tmr.sv
// Emitter settle timer: counts while enabled, flags the final settle cycle.
// Cleared on every frame start so each frame gets the full settle time.
module ir_settle_tmr
  import ir_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int          CYC  = FAST_SIM ? SETTLE_CYC_FAST : SETTLE_CYC;
  localparam logic [11:0] LAST = 12'(CYC - 1);

  logic [11:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (clr)
      cnt_reg <= '0;
    else if (en)
      cnt_reg <= cnt_reg + 12'd1;
  end

  assign done = en && (cnt_reg == LAST);

endmodule

// File: rtl/ir_err_calc.sv
// IR line-position error calculator: sequences 8 IR receivers through the A2D,
// accumulates a position-weighted right-minus-left sum, publishes it per frame.
module ir_err_calc
  import ir_pkg::*;
#(
  parameter bit          FAST_SIM   = 1'b0,
  parameter logic [11:0] LINE_THRES = 12'h040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        IR_en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [15:0] error,
  output logic        err_vld,
  output logic        line_present
);

  ir_state_t          state_reg, state_next;
  logic [1:0]         pair_reg;
  logic signed [17:0] acc_reg, acc_next;
  logic               line_reg, line_next;
  logic [15:0]        error_reg;
  logic               line_present_reg;

  logic               start_frame;
  logic               tmr_en;
  logic               tmr_done;
  logic               sample;
  logic               last_pair;
  logic signed [17:0] weighted;

  ir_settle_tmr #(.FAST_SIM(FAST_SIM)) u_settle_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_frame),
    .en   (tmr_en),
    .done (tmr_done)
  );

  // A result only counts while waiting on the conversion we requested.
  assign sample    = en && cnv_cmplt && (state_reg == WAIT_R || state_reg == WAIT_L);
  assign last_pair = (pair_reg == 2'(NUM_PAIRS - 1));
  assign weighted  = $signed({6'd0, res} << pair_reg);

  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    tmr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next  = SETTLE;
          start_frame = 1'b1;
        end
      end
      SETTLE: begin
        if (!en)
          state_next = IDLE;
        else begin
          tmr_en = 1'b1;
          if (tmr_done)
            state_next = CONV_R;
        end
      end
      CONV_R:  state_next = en ? WAIT_R : IDLE;
      WAIT_R: begin
        if (!en)
          state_next = IDLE;
        else if (cnv_cmplt)
          state_next = CONV_L;
      end
      CONV_L:  state_next = en ? WAIT_L : IDLE;
      WAIT_L: begin
        if (!en)
          state_next = IDLE;
        else if (cnv_cmplt)
          state_next = last_pair ? DONE : CONV_R;
      end
      DONE: begin
        if (en) begin
          state_next  = SETTLE;
          start_frame = 1'b1;
        end else
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next  = acc_reg;
    line_next = line_reg;
    if (sample) begin
      acc_next  = (state_reg == WAIT_R) ? acc_reg + weighted : acc_reg - weighted;
      line_next = line_reg || (res >= LINE_THRES);
    end
  end

  // Error is registered on the final sample so it is already valid in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      pair_reg         <= '0;
      acc_reg          <= '0;
      line_reg         <= 1'b0;
      error_reg        <= '0;
      line_present_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_frame) begin
        pair_reg <= '0;
        acc_reg  <= '0;
        line_reg <= 1'b0;
      end else begin
        acc_reg  <= acc_next;
        line_reg <= line_next;
        if (sample && state_reg == WAIT_L && !last_pair)
          pair_reg <= pair_reg + 2'd1;
      end
      if (sample && state_reg == WAIT_L && last_pair) begin
        error_reg        <= sat16(acc_next);
        line_present_reg <= line_next;
      end
    end
  end

  always_comb begin
    chnnl = 3'd0;
    case (state_reg)
      CONV_R, WAIT_R: chnnl = {pair_reg, 1'b0};
      CONV_L, WAIT_L: chnnl = {pair_reg, 1'b1};
      default:        chnnl = 3'd0;
    endcase
  end

  assign IR_en        = (state_reg == SETTLE) || (state_reg == CONV_R) || (state_reg == WAIT_R) ||
                        (state_reg == CONV_L) || (state_reg == WAIT_L);
  assign strt_cnv     = (state_reg == CONV_R) || (state_reg == CONV_L);
  assign err_vld      = (state_reg == DONE);
  assign error        = error_reg;
  assign line_present = line_present_reg;

endmodule
